// File: rtl/wb_timer.sv
`default_nettype none
// =============================================================================
// wb_timer : Wishbone slave prescaled countdown timer with sticky EXPIRED + IRQ
// Revision : 1.0
// =============================================================================
module wb_timer #(
  parameter logic [15:0] PRESCALE   = 16'd1,
  parameter logic [31:0] LOAD_RESET = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_adr_i,
  input  logic [1:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic        irq_o
);

  // A PRESCALE of 0 behaves like 1, so the terminal prescaler value is 0 then.
  localparam logic [15:0] C_PS_LAST = (PRESCALE == 16'd0) ? 16'd0 : (PRESCALE - 16'd1);

  localparam logic [1:0] C_ADR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADR_LOAD   = 2'd1;
  localparam logic [1:0] C_ADR_COUNT  = 2'd2;
  localparam logic [1:0] C_ADR_STATUS = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  reg_sel;
  logic [31:0] lane_mask;
  logic [2:0]  ctrl_wdata;
  logic [31:0] rd_mux;
  logic        tick;
  logic        expire;

  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] presc_q, presc_d;

  logic        unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Bus handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    access    = 1'b0;
    wbs_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          access  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        wbs_ack_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en     = access && wbs_we_i;
  assign rd_en     = access && !wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign lane_mask = {{16{wbs_sel_i[1]}}, {16{wbs_sel_i[0]}}};
  assign ctrl_wdata = ({ie_q, ar_q, en_q} & ~lane_mask[2:0]) | (wbs_dat_i[2:0] & lane_mask[2:0]);

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      C_ADR_CTRL:   rd_mux = {29'd0, ie_q, ar_q, en_q};
      C_ADR_LOAD:   rd_mux = load_q;
      C_ADR_COUNT:  rd_mux = count_q;
      C_ADR_STATUS: rd_mux = {31'd0, exp_q};
      default:      rd_mux = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timer datapath: hardware updates first, bus writes override where they win
  // ---------------------------------------------------------------------------
  assign tick   = en_q && (presc_q == C_PS_LAST);
  assign expire = tick && (count_q == 32'd0);

  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    dat_d   = dat_q;

    if (en_q) begin
      presc_d = tick ? 16'd0 : (presc_q + 16'd1);
    end

    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (ar_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (expire) begin
      exp_d = 1'b1;
    end

    if (wr_en) begin
      case (reg_sel)
        C_ADR_CTRL: begin
          en_d = ctrl_wdata[0];
          ar_d = ctrl_wdata[1];
          ie_d = ctrl_wdata[2];
          if (!en_q && ctrl_wdata[0]) begin
            presc_d = 16'd0;
          end
        end
        C_ADR_LOAD:  load_d  = (load_q & ~lane_mask) | (wbs_dat_i & lane_mask);
        C_ADR_COUNT: count_d = (count_q & ~lane_mask) | (wbs_dat_i & lane_mask);
        C_ADR_STATUS: begin
          // A same-edge expiry keeps the flag set.
          if (wbs_sel_i[0] && wbs_dat_i[0] && !expire) begin
            exp_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      dat_d = rd_mux;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= LOAD_RESET;
      count_q <= LOAD_RESET;
      presc_q <= 16'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign irq_o     = exp_q & ie_q;

endmodule

`default_nettype wire
